// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe: 3-stage valid/ready pipelined vedic multiplier, full 2*WIDTH-bit product.
//   clk, rst (async, active-high); in_valid/in_ready/in_a/in_b operand handshake;
//   out_valid/out_ready/out_p product handshake. Optional macro SIGNED_MODE_EN adds
//   in_signed (per-transaction two's-complement mode via sign-magnitude around the core).
module vedic_mult_pipe #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef SIGNED_MODE_EN
  input  logic               in_signed,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);
  localparam int HALF = WIDTH / 2;
  localparam int PW = 2 * WIDTH;
  logic w_adv3, w_adv2;
  logic r_v1, r_v2, r_out_valid;
  logic [WIDTH-1:0] w_a, w_b, r_a, r_b;
  logic [WIDTH-1:0] w_q0, w_q1, w_q2, w_q3, r_q0, r_q1, r_q2, r_q3;
  logic [PW-1:0] w_sum, w_res, r_out_p;
  assign w_adv3 = !r_out_valid || out_ready;
  assign w_adv2 = !r_v2 || w_adv3;
  assign in_ready = !r_v1 || w_adv2;
  assign out_valid = r_out_valid;
  assign out_p = r_out_p;
`ifdef SIGNED_MODE_EN
  logic w_neg, r_neg1, r_neg2;
  // Core is unsigned; the most negative operand's magnitude 2^(WIDTH-1) still fits WIDTH bits.
  assign w_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
  assign w_b = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
  assign w_neg = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
  assign w_res = r_neg2 ? -w_sum : w_sum;
`else
  assign w_a = in_a;
  assign w_b = in_b;
  assign w_res = w_sum;
`endif
  vedic_mul #(.N(HALF)) u_q0 (.i_a(r_a[HALF-1:0]),     .i_b(r_b[HALF-1:0]),     .o_p(w_q0));
  vedic_mul #(.N(HALF)) u_q1 (.i_a(r_a[WIDTH-1:HALF]), .i_b(r_b[HALF-1:0]),     .o_p(w_q1));
  vedic_mul #(.N(HALF)) u_q2 (.i_a(r_a[HALF-1:0]),     .i_b(r_b[WIDTH-1:HALF]), .o_p(w_q2));
  vedic_mul #(.N(HALF)) u_q3 (.i_a(r_a[WIDTH-1:HALF]), .i_b(r_b[WIDTH-1:HALF]), .o_p(w_q3));
  // Add tree is one bit wider than the product; the carry-out is provably zero and dropped by the cast.
  assign w_sum = PW'((PW+1)'(r_q0) + (((PW+1)'(r_q1) + (PW+1)'(r_q2)) << HALF) + ((PW+1)'(r_q3) << WIDTH));
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_out_valid <= 1'b0;
      r_a <= '0;
      r_b <= '0;
      r_q0 <= '0;
      r_q1 <= '0;
      r_q2 <= '0;
      r_q3 <= '0;
      r_out_p <= '0;
`ifdef SIGNED_MODE_EN
      r_neg1 <= 1'b0;
      r_neg2 <= 1'b0;
`endif
    end else begin
      if (in_ready) r_v1 <= in_valid;
      if (in_ready && in_valid) begin
        r_a <= w_a;
        r_b <= w_b;
`ifdef SIGNED_MODE_EN
        r_neg1 <= w_neg;
`endif
      end
      if (w_adv2) r_v2 <= r_v1;
      if (w_adv2 && r_v1) begin
        r_q0 <= w_q0;
        r_q1 <= w_q1;
        r_q2 <= w_q2;
        r_q3 <= w_q3;
`ifdef SIGNED_MODE_EN
        r_neg2 <= r_neg1;
`endif
      end
      if (w_adv3) r_out_valid <= r_v2;
      if (w_adv3 && r_v2) r_out_p <= w_res;
    end
endmodule

// vedic_mul: combinational N x N vedic multiplier, recursing on half-width products down to 2x2 cells.
module vedic_mul #(
  parameter int N = 8
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);
  localparam int H = N / 2;
  generate
    if (N == 2) begin : g_cell
      logic w_c, w_hh;
      // Carry out of the cross terms is set only when all four bits are one.
      assign w_c = i_a[1] & i_b[0] & i_a[0] & i_b[1];
      assign w_hh = i_a[1] & i_b[1];
      assign o_p = {w_hh & w_c, w_hh ^ w_c, (i_a[1] & i_b[0]) ^ (i_a[0] & i_b[1]), i_a[0] & i_b[0]};
    end else begin : g_split
      logic [N-1:0] w_q0, w_q1, w_q2, w_q3;
      vedic_mul #(.N(H)) u_q0 (.i_a(i_a[H-1:0]), .i_b(i_b[H-1:0]), .o_p(w_q0));
      vedic_mul #(.N(H)) u_q1 (.i_a(i_a[N-1:H]), .i_b(i_b[H-1:0]), .o_p(w_q1));
      vedic_mul #(.N(H)) u_q2 (.i_a(i_a[H-1:0]), .i_b(i_b[N-1:H]), .o_p(w_q2));
      vedic_mul #(.N(H)) u_q3 (.i_a(i_a[N-1:H]), .i_b(i_b[N-1:H]), .o_p(w_q3));
      assign o_p = (2*N)'((2*N+1)'(w_q0) + (((2*N+1)'(w_q1) + (2*N+1)'(w_q2)) << H) + ((2*N+1)'(w_q3) << N));
    end
  endgenerate
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// tb_vedic_mult_pipe: directed/self-checking bench for vedic_mult_pipe at WIDTH 16, 8 and 4.
module tb_vedic_mult_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic v16 = 1'b0, r16, ov16, or16 = 1'b1;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] p16;
  logic v8 = 1'b0, r8, ov8, or8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic [15:0] p8;
  logic v4 = 1'b0, r4, ov4, or4 = 1'b1;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] p4;
`ifdef SIGNED_MODE_EN
  logic s16 = 1'b0;
`endif
  vedic_mult_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_a(a16), .in_b(b16),
`ifdef SIGNED_MODE_EN
    .in_signed(s16),
`endif
    .out_valid(ov16), .out_ready(or16), .out_p(p16));
  vedic_mult_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(r8), .in_a(a8), .in_b(b8),
`ifdef SIGNED_MODE_EN
    .in_signed(1'b0),
`endif
    .out_valid(ov8), .out_ready(or8), .out_p(p8));
  vedic_mult_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_a(a4), .in_b(b4),
`ifdef SIGNED_MODE_EN
    .in_signed(1'b0),
`endif
    .out_valid(ov4), .out_ready(or4), .out_p(p4));

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (ov16 !== 1'b0 || p16 !== 32'h0) begin miscompares++; $display("FAIL reset16 out_valid=%b out_p=%h want 0/0", ov16, p16); end
    vectors++;
    if (ov8 !== 1'b0 || p8 !== 16'h0 || ov4 !== 1'b0 || p4 !== 8'h0) begin miscompares++; $display("FAIL reset8_4 ov8=%b p8=%h ov4=%b p4=%h want zeros", ov8, p8, ov4, p4); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (r16 !== 1'b1) begin miscompares++; $display("FAIL reset_ready in_ready=%b want 1", r16); end
  endtask

  task automatic test_max16;
    int lat;
    @(negedge clk);
    a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1; or16 = 1'b1;
    #1;
    vectors++;
    if (r16 !== 1'b1) begin miscompares++; $display("FAIL max16_ready in_ready=%b want 1", r16); end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    v16 = 1'b0;
    while (ov16 !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    vectors++;
    if (lat != 3) begin miscompares++; $display("FAIL max16_latency got %0d want 3", lat); end
    vectors++;
    if (p16 !== 32'hFFFE0001) begin miscompares++; $display("FAIL max16_product got %h want fffe0001", p16); end
  endtask

  task automatic test_back_to_back8;
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic [15:0] te [4];
    int n = 0;
    int first = -1;
    ta = '{8'hAB, 8'h00, 8'h01, 8'h80};
    tb = '{8'hCD, 8'h55, 8'hFF, 8'h02};
    te = '{16'h88EF, 16'h0000, 16'h00FF, 16'h0100};
    or8 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov8 === 1'b1) begin
        if (first < 0) first = k;
        vectors++;
        if (n > 3) begin miscompares++; $display("FAIL b2b8_extra got %h want no output", p8); end
        else if (p8 !== te[n] || k != first + n) begin miscompares++; $display("FAIL b2b8_out%0d got %h at %0d want %h at %0d", n, p8, k, te[n], first + n); end
        n++;
      end
      if (k < 4) begin
        a8 = ta[k]; b8 = tb[k]; v8 = 1'b1;
        #1;
        vectors++;
        if (r8 !== 1'b1) begin miscompares++; $display("FAIL b2b8_ready%0d in_ready=%b want 1", k, r8); end
      end else v8 = 1'b0;
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL b2b8_count got %0d want 4", n); end
  endtask

  task automatic test_backpressure16;
    logic [31:0] q [$];
    logic [31:0] held = '0;
    logic hold_chk = 1'b0;
    int acc = 0;
    int got = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (hold_chk) begin
        vectors++;
        if (ov16 !== 1'b1 || p16 !== held) begin miscompares++; $display("FAIL bp16_hold ov=%b p=%h want 1/%h", ov16, p16, held); end
      end
      if (ov16 === 1'b1 && !hold_chk) begin held = p16; hold_chk = 1'b1; end
      a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'b1; or16 = 1'b0;
      #1;
      if (r16 === 1'b1) begin q.push_back(32'(a16) * 32'(b16)); acc++; end
    end
    @(negedge clk);
    v16 = 1'b0;
    #1;
    vectors++;
    if (acc != 3 || r16 !== 1'b0) begin miscompares++; $display("FAIL bp16_capacity accepts=%0d in_ready=%b want 3/0", acc, r16); end
    vectors++;
    if (ov16 !== 1'b1 || p16 !== held) begin miscompares++; $display("FAIL bp16_hold_end ov=%b p=%h want 1/%h", ov16, p16, held); end
    or16 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (ov16 === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin miscompares++; $display("FAIL bp16_dup got %h want none", p16); end
        else begin
          if (p16 !== q[0]) begin miscompares++; $display("FAIL bp16_order got %h want %h", p16, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      @(negedge clk);
    end
    vectors++;
    if (got != 3 || q.size() != 0) begin miscompares++; $display("FAIL bp16_drain got %0d left %0d want 3/0", got, q.size()); end
  endtask

  task automatic test_width4;
    logic [7:0] q [$];
    int got = 0;
    or4 = 1'b1;
    for (int k = 0; k < 270; k++) begin
      @(negedge clk);
      if (ov4 === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin miscompares++; $display("FAIL w4_dup got %h want none", p4); end
        else begin
          if (p4 !== q[0]) begin miscompares++; $display("FAIL w4_product got %h want %h", p4, q[0]); end
          void'(q.pop_front());
        end
        got++;
      end
      if (k < 256) begin
        a4 = 4'(k >> 4); b4 = 4'(k); v4 = 1'b1;
        #1;
        if (r4 === 1'b1) q.push_back(8'(a4) * 8'(b4));
      end else v4 = 1'b0;
    end
    vectors++;
    if (got != 256 || q.size() != 0) begin miscompares++; $display("FAIL w4_count got %0d left %0d want 256/0", got, q.size()); end
  endtask

  task automatic test_random16;
    logic [31:0] q [$];
    logic [31:0] held = '0;
    logic held_v = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (held_v) begin
        vectors++;
        if (ov16 !== 1'b1 || p16 !== held) begin miscompares++; $display("FAIL rnd16_hold ov=%b p=%h want 1/%h", ov16, p16, held); end
      end
      v16 = ($urandom_range(0, 3) != 0) && (k < 360);
      a16 = 16'($urandom); b16 = 16'($urandom);
      or16 = ($urandom_range(0, 2) != 0) || (k >= 360);
      #1;
      if (ov16 === 1'b1 && or16) begin
        vectors++;
        if (q.size() == 0) begin miscompares++; $display("FAIL rnd16_dup got %h want none", p16); end
        else begin
          if (p16 !== q[0]) begin miscompares++; $display("FAIL rnd16_product got %h want %h", p16, q[0]); end
          void'(q.pop_front());
        end
      end
      held_v = (ov16 === 1'b1) && !or16;
      held = p16;
      if (v16 && r16 === 1'b1) q.push_back(32'(a16) * 32'(b16));
    end
    v16 = 1'b0;
    or16 = 1'b1;
    vectors++;
    if (q.size() != 0) begin miscompares++; $display("FAIL rnd16_lost left %0d want 0", q.size()); end
  endtask

  task automatic test_reset_mid;
    int lat;
    @(negedge clk);
    or16 = 1'b0; a16 = 16'd3; b16 = 16'd5; v16 = 1'b1;
    @(negedge clk);
    a16 = 16'd7; b16 = 16'd9;
    @(negedge clk);
    v16 = 1'b0;
    @(negedge clk);
    vectors++;
    if (ov16 !== 1'b1 || p16 !== 32'd15) begin miscompares++; $display("FAIL rstmid_pre ov=%b p=%h want 1/0000000f", ov16, p16); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (ov16 !== 1'b0 || p16 !== 32'h0) begin miscompares++; $display("FAIL rstmid_async ov=%b p=%h want 0/0", ov16, p16); end
    @(negedge clk);
    rst = 1'b0;
    or16 = 1'b1;
    #1;
    vectors++;
    if (r16 !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready in_ready=%b want 1", r16); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (ov16 !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale ov=%b p=%h want 0", ov16, p16); end
    end
    a16 = 16'd12; b16 = 16'd11; v16 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    v16 = 1'b0;
    while (ov16 !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    vectors++;
    if (lat != 3 || p16 !== 32'd132) begin miscompares++; $display("FAIL rstmid_next lat=%0d p=%h want 3/00000084", lat, p16); end
  endtask

`ifdef SIGNED_MODE_EN
  task automatic test_signed;
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic ts [4];
    logic [31:0] te [4];
    int n = 0;
    ta = '{16'hFFFF, 16'h8000, 16'hFFFD, 16'hFFFF};
    tb = '{16'hFFFF, 16'h8000, 16'h0005, 16'hFFFF};
    ts = '{1'b1, 1'b1, 1'b1, 1'b0};
    te = '{32'h00000001, 32'h40000000, 32'hFFFFFFF1, 32'hFFFE0001};
    or16 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ov16 === 1'b1) begin
        vectors++;
        if (n > 3) begin miscompares++; $display("FAIL signed_extra got %h want none", p16); end
        else if (p16 !== te[n]) begin miscompares++; $display("FAIL signed_out%0d got %h want %h", n, p16, te[n]); end
        n++;
      end
      if (k < 4) begin a16 = ta[k]; b16 = tb[k]; s16 = ts[k]; v16 = 1'b1; end
      else begin v16 = 1'b0; s16 = 1'b0; end
    end
    vectors++;
    if (n != 4) begin miscompares++; $display("FAIL signed_count got %0d want 4", n); end
  endtask
`endif

  initial begin
    test_reset;
    test_max16;
    test_back_to_back8;
    test_backpressure16;
    test_width4;
    test_random16;
    test_reset_mid;
`ifdef SIGNED_MODE_EN
    test_signed;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
